// File: rtl/sigencode_z_seq.sv
// Sequencer for the ML-DSA z-polynomial signature encoder: launches the encoder once per
// polynomial with strided source/destination addresses, with a per-polynomial watchdog.
`ifndef ABR_MEM_ADDR_WIDTH
`define ABR_MEM_ADDR_WIDTH 15
`endif

module sigencode_z_seq #(
    parameter int MEM_ADDR_WIDTH = `ABR_MEM_ADDR_WIDTH,
    parameter int MAX_POLYS      = 7,
    parameter int SRC_STRIDE     = 64,
    parameter int DEST_STRIDE    = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      zeroize,
    input  logic                      start,
    input  logic [2:0]                num_polys,
    input  logic [MEM_ADDR_WIDTH-1:0] src_base_addr,
    input  logic [MEM_ADDR_WIDTH-1:0] dest_base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [2:0]                poly_idx,
    output logic                      enc_enable,
    output logic [MEM_ADDR_WIDTH-1:0] enc_src_base_addr,
    output logic [MEM_ADDR_WIDTH-1:0] enc_dest_base_addr,
    input  logic                      enc_done
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

    localparam int                        TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]             TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] SRC_STEP   = MEM_ADDR_WIDTH'(SRC_STRIDE);
    localparam logic [MEM_ADDR_WIDTH-1:0] DEST_STEP  = MEM_ADDR_WIDTH'(DEST_STRIDE);

    state_t                    state_q, state_d;
    logic [2:0]                num_q, num_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic                      error_d;
    logic [2:0]                poly_idx_d;
    logic [MEM_ADDR_WIDTH-1:0] src_d, dest_d;

    logic cmd_ok, last_poly, timed_out;

    assign cmd_ok    = (num_polys != 3'd0) && (int'(num_polys) <= MAX_POLYS);
    assign last_poly = (poly_idx + 3'd1) == num_q;
    assign timed_out = timer_q == TIMER_LAST;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            state_q <= S_IDLE;
            num_q   <= 3'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            timer_q <= timer_d;
        end
    end

    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = cmd_ok ? S_LAUNCH : S_FINISH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (enc_done)       state_d = last_poly ? S_FINISH : S_LAUNCH;
                else if (timed_out) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so this computes their values for the state being entered.
    always_comb begin
        num_d      = num_q;
        timer_d    = timer_q;
        error_d    = error;
        poly_idx_d = poly_idx;
        src_d      = enc_src_base_addr;
        dest_d     = enc_dest_base_addr;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_ok) begin
                        num_d      = num_polys;
                        error_d    = 1'b0;
                        poly_idx_d = 3'd0;
                        src_d      = src_base_addr;
                        dest_d     = dest_base_addr;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: timer_d = '0;
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (enc_done && !last_poly) begin
                    poly_idx_d = poly_idx + 3'd1;
                    src_d      = enc_src_base_addr + SRC_STEP;
                    dest_d     = enc_dest_base_addr + DEST_STEP;
                end else if (!enc_done && timed_out) begin
                    error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            poly_idx           <= 3'd0;
            enc_enable         <= 1'b0;
            enc_src_base_addr  <= '0;
            enc_dest_base_addr <= '0;
        end else begin
            busy               <= state_d != S_IDLE;
            done               <= state_d == S_FINISH;
            error              <= error_d;
            poly_idx           <= poly_idx_d;
            enc_enable         <= state_d == S_LAUNCH;
            enc_src_base_addr  <= src_d;
            enc_dest_base_addr <= dest_d;
        end
    end

endmodule
